mapper_ese_ram_sd: RTL and testbench



---
 rtl/mapper_ese_ram_sd.sv | 178 +++++++++++++++++
 tb/tb_mapper_ese_ram_sd.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_ese_ram_sd.sv
// mapper_ese_ram_sd
// Bank-switched ESE-RAM cartridge mapper with an SPI master for an SD card.
// CPU accesses to 0x4000-0xBFFF are split into four 8 KB pages, each mapped
// to an SDRAM bank through its bank register. When bank[0] holds SD_BANK,
// page 0 becomes a memory-mapped SPI byte port instead of RAM.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cs, addr        slot select and CPU address
//   data_in         CPU write data
//   wr, rd          one-cycle write/read strobes, qualified by cs
//   ram_cs          SDRAM access request (combinational)
//   ram_addr        SDRAM byte address (combinational)
//   ram_rnw         1 = read, 0 = write (combinational)
//   data            read data for the SD window, 8'hFF otherwise
//   spi_sclk        SD clock (mode 0)
//   spi_mosi        SD data out
//   spi_cs_n        SD chip select, active low
//   spi_miso        SD data in, already synchronised
module mapper_ese_ram_sd #(
  parameter int          BANK_BITS = 6,
  parameter logic [26:0] RAM_BASE  = 27'h0,
  parameter int          SPI_DIV   = 2,
  parameter logic [7:0]  SD_BANK   = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        wr,
  input  logic        rd,
  output logic        ram_cs,
  output logic [26:0] ram_addr,
  output logic        ram_rnw,
  output logic [7:0]  data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);
  // Bank numbers wider than BANK_BITS are silently folded by this mask.
  localparam logic [6:0] BANK_MASK = 7'((1 << BANK_BITS) - 1);

  typedef enum logic {IDLE, SHIFT} spiState_e;

  logic [7:0]       bank_q [4];
  spiState_e        state_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_q;
  logic [2:0]       bitCnt_q;
  logic [DIV_W-1:0] divCnt_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             csn_q;

  logic       inRange;
  logic [1:0] page;
  logic       access;
  logic [7:0] pageReg;
  logic [6:0] bankNum;
  logic       sdActive;
  logic       sdPage;
  logic       sdDataWin;
  logic       sdCtrlWin;
  logic       regWrite;
  logic       ramRead;
  logic       ramWrite;
  logic       busy;
  logic       startXfer;
  logic [7:0] txByte;

  // 0x4000-0xBFFF is exactly the range where addr[15] and addr[14] differ.
  // Subtracting 2 from addr[14:13] turns 0x4000/0x6000/0x8000/0xA000 into
  // pages 0/1/2/3.
  assign inRange  = addr[15] ^ addr[14];
  assign page     = addr[14:13] - 2'd2;
  assign access   = cs & inRange;
  assign pageReg  = bank_q[page];
  assign bankNum  = pageReg[6:0] & BANK_MASK;
  assign sdActive = (bank_q[0] == SD_BANK);
  assign sdPage   = (page == 2'd0) & sdActive;

  // Within the SD page, 0x5800-0x5FFF is control/status, the rest is data.
  assign sdDataWin = access & sdPage & (addr[12:11] != 2'b11);
  assign sdCtrlWin = access & sdPage & (addr[12:11] == 2'b11);

  // Page 1 is always register space for writes, so it can never be written.
  assign regWrite = access & wr & (page == 2'd1);
  assign ramRead  = access & rd & ~sdPage;
  assign ramWrite = access & wr & ~sdPage & (page != 2'd1) & pageReg[7];

  assign ram_cs   = ramRead | ramWrite;
  assign ram_rnw  = ~wr;
  assign ram_addr = RAM_BASE + {7'b0, bankNum, addr[12:0]};

  assign busy      = (state_q == SHIFT);
  assign startXfer = ~busy & sdDataWin & (wr | rd);
  assign txByte    = wr ? data_in : 8'hFF;

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = csn_q;

  // Read mux: only SD window reads return data, everything else floats high.
  always_comb begin
    data = 8'hFF;
    if (sdDataWin & rd) begin
      data = rx_q;
    end else if (sdCtrlWin & rd) begin
      data = {6'b0, ~csn_q, busy};
    end
  end

  // Bank registers, SD chip select and the SPI shift engine. Each bit is a
  // low half then a high half of SPI_DIV cycles; MISO is captured as SCLK
  // rises and the next MOSI bit is presented as SCLK falls, so the byte
  // being sent and the byte being received share one shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= 8'h00;
      end
      state_q  <= IDLE;
      shift_q  <= 8'hFF;
      rx_q     <= 8'hFF;
      bitCnt_q <= 3'd0;
      divCnt_q <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      csn_q    <= 1'b1;
    end else begin
      if (regWrite) begin
        bank_q[addr[12:11]] <= data_in;
      end
      if (sdCtrlWin & wr) begin
        csn_q <= ~data_in[0];
      end
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          mosi_q <= 1'b1;
          if (startXfer) begin
            state_q  <= SHIFT;
            shift_q  <= txByte;
            mosi_q   <= txByte[7];
            bitCnt_q <= 3'd7;
            divCnt_q <= '0;
          end
        end
        SHIFT: begin
          if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
            if (!sclk_q) begin
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[6:0], spi_miso};
            end else if (bitCnt_q == 3'd0) begin
              sclk_q  <= 1'b0;
              rx_q    <= shift_q;
              state_q <= IDLE;
            end else begin
              sclk_q   <= 1'b0;
              mosi_q   <= shift_q[7];
              bitCnt_q <= bitCnt_q - 3'd1;
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_ese_ram_sd.sv
// tb_mapper_ese_ram_sd
// Directed testbench for mapper_ese_ram_sd. One instance uses the default
// parameters; a second one (BANK_BITS=3, RAM_BASE=27'h7FFE000) shares the
// CPU-side inputs to exercise bank masking and address wrap. MISO of each
// instance is looped back from its own MOSI.
module tb_mapper_ese_ram_sd;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [15:0] addr;
  logic [7:0]  dataIn;
  logic        wr;
  logic        rd;

  logic        ramCs, ramRnw, spiSclk, spiMosi, spiCsN;
  logic [26:0] ramAddr;
  logic [7:0]  dataOut;

  logic        ramCsB, ramRnwB, spiSclkB, spiMosiB, spiCsNB;
  logic [26:0] ramAddrB;
  logic [7:0]  dataOutB;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mapper_ese_ram_sd #(
    .BANK_BITS(6), .RAM_BASE(27'h0), .SPI_DIV(D), .SD_BANK(8'h40)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data_in(dataIn),
    .wr(wr), .rd(rd), .ram_cs(ramCs), .ram_addr(ramAddr), .ram_rnw(ramRnw),
    .data(dataOut), .spi_sclk(spiSclk), .spi_mosi(spiMosi),
    .spi_cs_n(spiCsN), .spi_miso(spiMosi)
  );

  mapper_ese_ram_sd #(
    .BANK_BITS(3), .RAM_BASE(27'h7FFE000), .SPI_DIV(D), .SD_BANK(8'h40)
  ) dutB (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data_in(dataIn),
    .wr(wr), .rd(rd), .ram_cs(ramCsB), .ram_addr(ramAddrB), .ram_rnw(ramRnwB),
    .data(dataOutB), .spi_sclk(spiSclkB), .spi_mosi(spiMosiB),
    .spi_cs_n(spiCsNB), .spi_miso(spiMosiB)
  );

  // Drive one CPU access starting at a falling edge; outputs are settled
  // on return and the strobe stays up across the next rising edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic w, input logic r, input logic c);
    @(negedge clk);
    addr = a; dataIn = d; wr = w; rd = r; cs = c;
    #1;
  endtask

  task automatic endStimulus;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    #1;
  endtask

  // Poll the status register until busy clears, with a cycle bound.
  task automatic waitNotBusy(output int n);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h5800;
    #1;
    n = 0;
    while (dataOut[0] === 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cs = 0; wr = 0; rd = 0; addr = 16'h0; dataIn = 8'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_cs got %b want 0", ramCs); end
    compared++; if (dataOut !== 8'hFF) begin mismatched++; $display("[TB] FAIL reset_data got %h want ff", dataOut); end
    compared++; if (spiCsN !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cs_n got %b want 1", spiCsN); end
    compared++; if (spiSclk !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sclk got %b want 0", spiSclk); end
    compared++; if (spiMosi !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_mosi got %b want 1", spiMosi); end
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramCs !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rd_ram_cs got %b want 1", ramCs); end
    compared++; if (ramAddr !== 27'h0) begin mismatched++; $display("[TB] FAIL reset_rd_addr got %h want 0", ramAddr); end
    compared++; if (dataOut !== 8'hFF) begin mismatched++; $display("[TB] FAIL reset_rd_data got %h want ff", dataOut); end
    endStimulus;
  endtask

  task automatic test_bank_map;
    applyStimulus(16'h7000, 8'h05, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL regwr_ram_cs got %b want 0", ramCs); end
    endStimulus;
    applyStimulus(16'h8123, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramCs !== 1'b1) begin mismatched++; $display("[TB] FAIL map_ram_cs got %b want 1", ramCs); end
    compared++; if (ramRnw !== 1'b1) begin mismatched++; $display("[TB] FAIL map_rnw got %b want 1", ramRnw); end
    compared++; if (ramAddr !== 27'h000A123) begin mismatched++; $display("[TB] FAIL map_addr got %h want 000a123", ramAddr); end
    endStimulus;
    applyStimulus(16'h7800, 8'h12, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'hA001, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramAddr !== 27'h0024001) begin mismatched++; $display("[TB] FAIL map_page3_addr got %h want 0024001", ramAddr); end
    endStimulus;
    applyStimulus(16'h6010, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramCs !== 1'b1 || ramAddr !== 27'h0000010) begin mismatched++; $display("[TB] FAIL page1_read got cs=%b addr=%h want cs=1 addr=0000010", ramCs, ramAddr); end
    endStimulus;
    applyStimulus(16'hC000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramCs !== 1'b0 || dataOut !== 8'hFF) begin mismatched++; $display("[TB] FAIL out_of_range got cs=%b data=%h want cs=0 data=ff", ramCs, dataOut); end
    endStimulus;
    applyStimulus(16'h8000, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL no_cs_read got %b want 0", ramCs); end
    endStimulus;
  endtask

  task automatic test_write_enable;
    applyStimulus(16'h7000, 8'h85, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h8000, 8'h11, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b1 || ramRnw !== 1'b0) begin mismatched++; $display("[TB] FAIL we_on got cs=%b rnw=%b want cs=1 rnw=0", ramCs, ramRnw); end
    compared++; if (ramAddr !== 27'h000A000) begin mismatched++; $display("[TB] FAIL we_on_addr got %h want 000a000", ramAddr); end
    endStimulus;
    applyStimulus(16'h7000, 8'h05, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h8000, 8'h11, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL we_off got %b want 0", ramCs); end
    endStimulus;
    applyStimulus(16'h6800, 8'h85, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h6800, 8'h85, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL page1_write got %b want 0", ramCs); end
    endStimulus;
    applyStimulus(16'h6000, 8'h80, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h4000, 8'h22, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b1 || ramAddr !== 27'h0) begin mismatched++; $display("[TB] FAIL page0_we got cs=%b addr=%h want cs=1 addr=0", ramCs, ramAddr); end
    endStimulus;
  endtask

  task automatic test_mask_wrap;
    applyStimulus(16'h7800, 8'h0F, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'hA123, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramAddrB !== 27'h000C123) begin mismatched++; $display("[TB] FAIL mask_addr_b got %h want 000c123", ramAddrB); end
    compared++; if (ramAddr !== 27'h001E123) begin mismatched++; $display("[TB] FAIL nomask_addr got %h want 001e123", ramAddr); end
    endStimulus;
    applyStimulus(16'h7000, 8'h01, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h8123, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (ramCsB !== 1'b1 || ramAddrB !== 27'h0000123) begin mismatched++; $display("[TB] FAIL wrap_addr_b got cs=%b addr=%h want cs=1 addr=0000123", ramCsB, ramAddrB); end
    compared++; if (ramAddr !== 27'h0002123) begin mismatched++; $display("[TB] FAIL bank1_addr got %h want 0002123", ramAddr); end
    endStimulus;
  endtask

  task automatic test_sd_transfer;
    logic [7:0] bits;
    int c;
    bits = 8'h00;
    applyStimulus(16'h6000, 8'h40, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h5800, 8'h01, 1'b1, 1'b0, 1'b1);
    endStimulus;
    compared++; if (spiCsN !== 1'b0) begin mismatched++; $display("[TB] FAIL sd_cs_n got %b want 0", spiCsN); end
    applyStimulus(16'h4000, 8'hA5, 1'b1, 1'b0, 1'b1);
    compared++; if (ramCs !== 1'b0) begin mismatched++; $display("[TB] FAIL sd_page_ram_cs got %b want 0", ramCs); end
    endStimulus;
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h5800;
    #1;
    compared++; if (dataOut !== 8'h03) begin mismatched++; $display("[TB] FAIL sd_status_busy got %h want 03", dataOut); end
    c = 0;
    while (dataOut[0] === 1'b1 && c < 200) begin
      if (c < 16 * D && (c % (2 * D)) == 0) bits[7 - c / (2 * D)] = spiMosi;
      c++;
      @(negedge clk); #1;
    end
    compared++; if (c !== 16 * D) begin mismatched++; $display("[TB] FAIL sd_busy_len got %0d want %0d", c, 16 * D); end
    compared++; if (bits !== 8'hA5) begin mismatched++; $display("[TB] FAIL sd_mosi_bits got %h want a5", bits); end
    compared++; if (dataOut !== 8'h02) begin mismatched++; $display("[TB] FAIL sd_status_idle got %h want 02", dataOut); end
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic test_sd_read;
    int c, pulses, badMosi, n;
    logic prev;
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (dataOut !== 8'hA5) begin mismatched++; $display("[TB] FAIL sd_rx_a5 got %h want a5", dataOut); end
    endStimulus;
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h5800;
    #1;
    c = 0; pulses = 0; badMosi = 0; prev = 1'b0;
    while (dataOut[0] === 1'b1 && c < 200) begin
      if (spiSclk === 1'b1 && prev === 1'b0) pulses++;
      if (spiSclk === 1'b1 && spiMosi !== 1'b1) badMosi++;
      prev = spiSclk;
      c++;
      @(negedge clk); #1;
    end
    cs = 1'b0; rd = 1'b0;
    compared++; if (pulses !== 8) begin mismatched++; $display("[TB] FAIL sd_read_pulses got %0d want 8", pulses); end
    compared++; if (badMosi !== 0) begin mismatched++; $display("[TB] FAIL sd_read_mosi got %0d low bits want 0", badMosi); end
    compared++; if (c !== 16 * D) begin mismatched++; $display("[TB] FAIL sd_read_len got %0d want %0d", c, 16 * D); end
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (dataOut !== 8'hFF) begin mismatched++; $display("[TB] FAIL sd_rx_ff got %h want ff", dataOut); end
    endStimulus;
    waitNotBusy(n);
    compared++; if (n >= 200) begin mismatched++; $display("[TB] FAIL sd_read_timeout got %0d want <200", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    applyStimulus(16'h4000, 8'h3C, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h4000, 8'hC3, 1'b1, 1'b0, 1'b1);
    endStimulus;
    waitNotBusy(n);
    compared++; if (n >= 200) begin mismatched++; $display("[TB] FAIL b2b_timeout got %0d want <200", n); end
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (dataOut !== 8'h3C) begin mismatched++; $display("[TB] FAIL b2b_rx got %h want 3c", dataOut); end
    endStimulus;
    waitNotBusy(n);
  endtask

  task automatic test_reset_abort;
    int n;
    applyStimulus(16'h4000, 8'h5A, 1'b1, 1'b0, 1'b1);
    endStimulus;
    waitNotBusy(n);
    applyStimulus(16'h4000, 8'h00, 1'b1, 1'b0, 1'b1);
    endStimulus;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++; if (spiSclk !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_sclk got %b want 0", spiSclk); end
    compared++; if (spiCsN !== 1'b1 || spiMosi !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_pins got cs_n=%b mosi=%b want 1 1", spiCsN, spiMosi); end
    applyStimulus(16'h6000, 8'h40, 1'b1, 1'b0, 1'b1);
    endStimulus;
    applyStimulus(16'h5800, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (dataOut !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_status got %h want 00", dataOut); end
    endStimulus;
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++; if (dataOut !== 8'hFF) begin mismatched++; $display("[TB] FAIL abort_rx got %h want ff", dataOut); end
    endStimulus;
    waitNotBusy(n);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_bank_map;
    test_write_enable;
    test_mask_wrap;
    test_sd_transfer;
    test_sd_read;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
